// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// lane-enable patterns and the error word returned on a timed-out load.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0]  BE_WORD  = 4'hF;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    // Byte accesses light the single lane selected by the low address bits.
    function automatic logic [3:0] lane_be(input logic byte_op, input logic [1:0] lane);
        return byte_op ? (4'b0001 << lane) : BE_WORD;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Formats raw bus read data into the load result: full word, or the
// addressed byte zero-extended.
module load_align (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic        byte_op_i,
    output logic [31:0] data_o
);

    assign data_o = byte_op_i ? {24'd0, rdata_i[8*lane_i +: 8]} : rdata_i;

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: IDLE -> BUS -> DONE handshake with the data bus.
// Optional bus timeout and sticky BusErr enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        ByteOp,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    state_e      state_q, state_d;
    logic [31:2] addr_q;
    logic [1:0]  lane_q;
    logic        byte_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] load_word;
    logic        start;
    logic        acked;
    logic        timeout;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign start = (state_q == IDLE) && (MemWrite || MemRead);
    assign acked = (state_q == BUS) && bus_ack;

    load_align u_align (
        .rdata_i   (bus_rdata),
        .lane_i    (lane_q),
        .byte_op_i (byte_q),
        .data_o    (load_word)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Terminal count is the last wait cycle; an ack arriving then still completes.
    assign timeout = (state_q == BUS) && !bus_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (start) begin
                cnt_q <= '0;
            end else if (state_q == BUS && !bus_ack) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign BusErr = err_q;
`else
    assign timeout = 1'b0;
    assign BusErr  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUS;
            BUS:     if (acked || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
            byte_q  <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            // Write wins when both requests are raised together.
            if (start) begin
                addr_q  <= ALUResult[31:2];
                lane_q  <= ALUResult[1:0];
                byte_q  <= ByteOp;
                we_q    <= MemWrite;
                be_q    <= lane_be(ByteOp, ALUResult[1:0]);
                wdata_q <= ByteOp ? {4{WriteData[7:0]}} : WriteData;
            end
            if (acked && !we_q) begin
                rdata_q <= load_word;
            end else if (timeout && !we_q) begin
                rdata_q <= ERR_DATA;
            end
        end
    end

    assign bus_req   = (state_q == BUS);
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q, 2'b00};
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign ReadData  = rdata_q;

    assign Stall = !reset && (((state_q == IDLE) && (MemWrite || MemRead)) || (state_q == BUS));

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// transactions checked against an arithmetic model of the load/store rules.
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset, MemWrite, MemRead, ByteOp, bus_ack;
    logic [31:0] ALUResult, WriteData, bus_rdata;
    logic [31:0] ReadData, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        Stall, BusErr, bus_req, bus_we;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_rd;
    logic        exp_err;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead), .ByteOp(ByteOp),
        .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .BusErr(BusErr), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b1; ByteOp = 1'b0;
        ALUResult = 32'h0; WriteData = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
        step(); step();
        #1;
        n_chk++;
        if (Stall !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 ||
            bus_be !== 4'h0 || bus_wdata !== 32'h0 || ReadData !== 32'h0 || BusErr !== 1'b0)
            $display("FAIL reset: stall=%b req=%b we=%b addr=%h be=%h wd=%h rd=%h err=%b, expected all zero",
                     Stall, bus_req, bus_we, bus_addr, bus_be, bus_wdata, ReadData, BusErr);
        else n_pass++;
        reset = 1'b0; MemRead = 1'b0;
        exp_rd = 32'h0; exp_err = 1'b0;
    endtask

    task automatic test_idle_ack();
        step();
        MemWrite = 1'b0; MemRead = 1'b0; bus_ack = 1'b1; bus_rdata = $urandom;
        #1;
        n_chk++;
        if (Stall !== 1'b0 || bus_req !== 1'b0)
            $display("FAIL idle: stall=%b req=%b, expected 0 0", Stall, bus_req);
        else n_pass++;
        step();
        bus_ack = 1'b0;
        #1;
        n_chk++;
        if (bus_req !== 1'b0 || ReadData !== exp_rd)
            $display("FAIL idle_ack_ignored: req=%b rd=%h, expected 0 %h", bus_req, ReadData, exp_rd);
        else n_pass++;
    endtask

    // One instruction from its first (IDLE) cycle through DONE; ack after 'waits' wait cycles.
    task automatic txn(input string nm, input logic we, input logic re, input logic bop,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                       input int waits);
        logic [1:0]  ln;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        int          stalls;
        ln     = addr[1:0];
        e_addr = addr & 32'hFFFF_FFFC;
        e_be   = bop ? 4'(1 << ln) : 4'hF;
        e_wd   = bop ? {4{wd[7:0]}} : wd;
        stalls = 0;
        step();
        MemWrite = we; MemRead = re; ByteOp = bop; ALUResult = addr; WriteData = wd;
        bus_ack = 1'b0; bus_rdata = $urandom;
        #1;
        if (Stall === 1'b1) stalls++;
        for (int w = 0; w <= waits; w++) begin
            step();
            bus_ack = (w == waits);
            bus_rdata = (w == waits) ? rd : $urandom;
            #1;
            if (Stall === 1'b1) stalls++;
            n_chk++;
            if (bus_req !== 1'b1 || bus_we !== we || bus_addr !== e_addr || bus_be !== e_be ||
                (we && bus_wdata !== e_wd) || ReadData !== exp_rd)
                $display("FAIL %s bus: req=%b we=%b addr=%h be=%b wd=%h rd=%h, expected 1 %b %h %b %h %h",
                         nm, bus_req, bus_we, bus_addr, bus_be, bus_wdata, ReadData,
                         we, e_addr, e_be, e_wd, exp_rd);
            else n_pass++;
        end
        step();
        bus_ack = 1'b0;
        #1;
        if (!we) exp_rd = bop ? ((rd >> (8 * ln)) & 32'hFF) : rd;
        n_chk++;
        if (Stall !== 1'b0 || bus_req !== 1'b0)
            $display("FAIL %s done: stall=%b req=%b, expected 0 0", nm, Stall, bus_req);
        else n_pass++;
        n_chk++;
        if (ReadData !== exp_rd || BusErr !== exp_err)
            $display("FAIL %s readdata: rd=%h err=%b, expected %h %b", nm, ReadData, BusErr, exp_rd, exp_err);
        else n_pass++;
        n_chk++;
        if (stalls != 2 + waits)
            $display("FAIL %s stall_cycles: got %0d, expected %0d", nm, stalls, 2 + waits);
        else n_pass++;
    endtask

    task automatic test_directed();
        txn("word_store", 1'b1, 1'b0, 1'b0, 32'h100, 32'h12345678, 32'h0, 0);
        test_idle_ack();
        txn("byte_load", 1'b0, 1'b1, 1'b1, 32'h203, 32'h0, 32'hAABBCCDD, 3);
        txn("byte_store", 1'b1, 1'b0, 1'b1, 32'h41, 32'hFFFFFF5A, 32'h0, 1);
        txn("write_wins", 1'b1, 1'b1, 1'b0, 32'h2C, 32'hCAFEF00D, 32'h77777777, 0);
        txn("b2b_load_a", 1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0BADF00D, 0);
        txn("b2b_load_b", 1'b0, 1'b1, 1'b1, 32'h82, 32'h0, 32'h00C30000, 0);
        test_idle_ack();
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int op;
            logic w, r;
            op = $urandom_range(0, 2);
            w  = (op != 1);
            r  = (op != 0);
            txn("random", w, r, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) test_idle_ack();
        end
    endtask

    task automatic test_reset_mid();
        step();
        MemWrite = 1'b0; MemRead = 1'b1; ByteOp = 1'b0; ALUResult = 32'h300; bus_ack = 1'b0;
        step(); step();
        step();
        reset = 1'b1;
        #1;
        n_chk++;
        if (Stall !== 1'b0)
            $display("FAIL reset_mid_stall: stall=%b, expected 0", Stall);
        else n_pass++;
        step();
        reset = 1'b0; MemRead = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h11111111;
        exp_rd = 32'h0; exp_err = 1'b0;
        #1;
        n_chk++;
        if (bus_req !== 1'b0 || Stall !== 1'b0 || ReadData !== 32'h0)
            $display("FAIL reset_mid: req=%b stall=%b rd=%h, expected 0 0 0", bus_req, Stall, ReadData);
        else n_pass++;
        step();
        bus_ack = 1'b0;
        #1;
        n_chk++;
        if (bus_req !== 1'b0 || ReadData !== 32'h0 || BusErr !== 1'b0)
            $display("FAIL late_ack: req=%b rd=%h err=%b, expected 0 0 0", bus_req, ReadData, BusErr);
        else n_pass++;
    endtask

    task automatic test_long_wait();
        int req_cycles;
        req_cycles = 0;
        step();
        MemWrite = 1'b0; MemRead = 1'b1; ByteOp = 1'b0; ALUResult = 32'h500; bus_ack = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            #1;
            if (bus_req === 1'b1) req_cycles++;
            else break;
        end
`ifdef MEM_TIMEOUT_EN
        n_chk++;
        if (req_cycles != TO)
            $display("FAIL timeout_cycles: got %0d, expected %0d", req_cycles, TO);
        else n_pass++;
        exp_rd = 32'hDEADBEEF; exp_err = 1'b1;
        n_chk++;
        if (BusErr !== 1'b1 || ReadData !== exp_rd || Stall !== 1'b0)
            $display("FAIL timeout: err=%b rd=%h stall=%b, expected 1 %h 0", BusErr, ReadData, Stall, exp_rd);
        else n_pass++;
        txn("sticky_err", 1'b1, 1'b0, 1'b0, 32'h600, 32'h5555AAAA, 32'h0, 0);
        test_reset();
        txn("ack_at_terminal", 1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 32'h13579BDF, TO - 1);
`else
        n_chk++;
        if (req_cycles != 300 || BusErr !== 1'b0 || Stall !== 1'b1)
            $display("FAIL no_timeout: req_cycles=%0d err=%b stall=%b, expected 300 0 1",
                     req_cycles, BusErr, Stall);
        else n_pass++;
        bus_ack = 1'b1; bus_rdata = 32'h2468ACE0;
        step();
        bus_ack = 1'b0;
        #1;
        exp_rd = 32'h2468ACE0;
        n_chk++;
        if (ReadData !== exp_rd || bus_req !== 1'b0 || BusErr !== 1'b0)
            $display("FAIL long_wait_done: rd=%h req=%b err=%b, expected %h 0 0",
                     ReadData, bus_req, BusErr, exp_rd);
        else n_pass++;
`endif
        test_idle_ack();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_long_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit between the core's execute stage and an external data-memory bus. It takes the ALU-computed address and store data, runs a request/acknowledge transaction, and returns aligned load data as `ReadData` to the writeback result mux. While a transaction is in flight it stalls the core.

## Interface
- `TIMEOUT_CYCLES`, default 255: BUS-state cycles without `bus_ack` before abort. Used only with `MEM_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `MemWrite` in 1: store request from the control unit.
- `MemRead` in 1: load request (asserted together with `MemtoReg`).
- `ByteOp` in 1: 1 = byte access (LDRB/STRB), 0 = word.
- `ALUResult` in 32: effective address.
- `WriteData` in 32: store data.
- `ReadData` out 32: registered load result, valid in DONE and held until the next load completes.
- `Stall` out 1: hold the PC and pipeline while high.
- `BusErr` out 1: sticky timeout flag.
- `bus_req` out 1: transaction request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word-aligned address, bits [1:0] = 00.
- `bus_be` out 4: byte-lane enables.
- `bus_wdata` out 32: write data.
- `bus_rdata` in 32: read data, valid when `bus_ack` is high.
- `bus_ack` in 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, BUS, DONE.
- **IDLE**
  - If `MemWrite | MemRead`: register the address, data, lanes and direction; go to BUS.
  - If both are high, the write wins and the read is ignored.
- **BUS**
  - `bus_req` = 1; `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` stay stable until ack.
  - On `bus_ack`, a load registers the formatted `bus_rdata` into `ReadData`; go to DONE.
- **DONE**
  - `Stall` = 0, so the core advances on this edge.
  - Requests are ignored here because the same instruction is still presented; go to IDLE.
- **Stall**: combinational. High in IDLE when a request is present, and always high in BUS. Low in DONE, in idle with no request, and while `reset` is high.
- **Word access**: `bus_be` = 4'hF. `bus_wdata` = `WriteData`. `ReadData` = `bus_rdata`. Address bits [1:0] are ignored (no rotate).
- **Byte store**: `bus_be` = 4'b0001 << addr[1:0]. `bus_wdata` = `{4{WriteData[7:0]}}`.
- **Byte load**: `ReadData` = zero-extended `bus_rdata[8*addr[1:0] +: 8]`.
- A store never changes `ReadData`.
- `bus_ack` outside BUS is ignored.
- **Reset values**: state IDLE; `ReadData`, `bus_addr`, `bus_wdata` = 0; `bus_be` = 0; `bus_req`, `bus_we`, `BusErr` = 0.
- **Reset mid-transaction**: the FSM returns to IDLE and `bus_req` is low from the next cycle. A late `bus_ack` is then ignored.

## Timing
- Zero-wait bus (ack in the first BUS cycle): request seen in cycle t → BUS in t+1 → DONE in t+2. `Stall` is high in t and t+1, so a memory instruction occupies 3 cycles.
- Each wait cycle adds one cycle in BUS.
- `bus_req` is a decode of the state register and has no combinational path from the bus inputs.
- `ReadData` updates on the edge ending the ack cycle and is stable throughout DONE.

## Configuration
- **`MEM_TIMEOUT_EN` defined**
  - An 8-bit-or-wider counter clears on BUS entry and increments each BUS cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`: drop `bus_req`, set `BusErr` (sticky until reset), and go to DONE.
  - A load that times out returns `ReadData` = 32'hDEADBEEF.
  - An ack in the same cycle as the terminal count wins: the transaction completes normally and there is no error.
- **Not defined**
  - The unit waits in BUS indefinitely.
  - `BusErr` is tied to 0 and there is no counter.

## Structure
- **Package `mem_access_pkg`** holds:
  - the state enum (IDLE/BUS/DONE);
  - the constants `BE_WORD` = 4'hF and `ERR_DATA` = 32'hDEADBEEF;
  - the lane-enable function.
- **Sub-module `load_align`** is combinational: inputs `bus_rdata`, addr[1:0] and `ByteOp`; output is the formatted load word.

## Test plan
- **Word store, zero-wait**: addr 0x100, data 0x12345678, ack in the first BUS cycle → `bus_addr`=0x100, `bus_be`=F, `bus_we`=1, `Stall` high for 2 cycles, `ReadData` unchanged.
- **Byte load**: addr 0x203, `bus_rdata`=0xAABBCCDD, 3 wait cycles → `bus_addr`=0x200, `bus_be`=4'b1000, `ReadData`=0x000000AA in DONE, `Stall` high for 5 cycles.
- **Byte store**: addr 0x41, `WriteData`=0xFFFFFF5A → `bus_be`=4'b0010, `bus_wdata`=0x5A5A5A5A.
- **Simultaneous `MemWrite` and `MemRead`** → a single write transaction, `ReadData` unchanged. Back-to-back loads → DONE ignores the held request, and the second transaction starts from IDLE.
- **Reset during BUS**: reset after 2 wait cycles, then ack → state IDLE, `bus_req`=0, `ReadData`=0, the ack is ignored, `Stall`=0.
- **`MEM_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4**, load, no ack → `bus_req` drops after 4 BUS cycles, `BusErr`=1 sticky, `ReadData`=0xDEADBEEF. A repeat run with ack on the 4th cycle → no error.
